color_classifier: RTL and testbench

COLOR_CLASSIFIER -- requirements
Module: color_classifier

---
 rtl/color_pkg.sv | 27 ++
 rtl/color_classifier_if.sv | 26 ++
 rtl/color_window_acc.sv | 53 +++++
 rtl/color_classifier.sv | 149 ++++++++++++++
 tb/tb_color_classifier.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/color_pkg.sv
// Shared types and default thresholds for the colour classifier slice.
package color_pkg;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_BLACK = 3'd1,
        CLS_WHITE = 3'd2,
        CLS_RED   = 3'd3,
        CLS_GREEN = 3'd4,
        CLS_BLUE  = 3'd5,
        CLS_MIXED = 3'd6
    } class_t;

    typedef enum logic [1:0] {
        ST_ACCUM    = 2'd0,
        ST_AVG      = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_COMMIT   = 2'd3
    } state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_WIN_LOG2   = 10;
    localparam int DEF_STABLE_N   = 3;
    localparam int DEF_BW_TOL     = 16;
    localparam int DEF_DOM_MARGIN = 32;

endpackage

// File: rtl/color_classifier_if.sv
// Pixel stream in, window classification out.
// RGB_VDE is a valid with no ready: the block accepts every pixel presented while it is high.
interface color_classifier_if #(
    parameter int DATA_W = 8
);
    logic [3*DATA_W-1:0] RGB_Data;
    logic                RGB_VDE;
    logic                RGB_VSync;
    logic [3*DATA_W-1:0] Avg_RGB;
    logic [2:0]          Class_Code;
    logic                Class_Valid;
    logic                Class_Change;
    logic                LED_R;
    logic                LED_G;
    logic                LED_B;

    modport master (
        output RGB_Data, RGB_VDE, RGB_VSync,
        input  Avg_RGB, Class_Code, Class_Valid, Class_Change, LED_R, LED_G, LED_B
    );

    modport slave (
        input  RGB_Data, RGB_VDE, RGB_VSync,
        output Avg_RGB, Class_Code, Class_Valid, Class_Change, LED_R, LED_G, LED_B
    );
endinterface

// File: rtl/color_window_acc.sv
// Per-channel window accumulator; strobes close_o with the window average on the last pixel.
module color_window_acc #(
    parameter int DATA_W   = 8,
    parameter int WIN_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pix_valid_i,
    input  logic                frame_start_i,
    input  logic [3*DATA_W-1:0] pix_i,
    output logic                close_o,
    output logic [3*DATA_W-1:0] avg_o
);
    localparam int ACC_W = DATA_W + WIN_LOG2;

    logic [ACC_W-1:0]    acc_q [3];
    logic [ACC_W-1:0]    acc_d [3];
    logic [ACC_W-1:0]    sum   [3];
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;

    // A frame start wins over a close: the coincident pixel seeds the new window.
    always_comb begin
        close_o = pix_valid_i && !frame_start_i && (cnt_q == '1);
        cnt_d   = cnt_q;
        avg_o   = '0;
        for (int i = 0; i < 3; i++) begin
            sum[i]   = acc_q[i] + ACC_W'(pix_i[(2-i)*DATA_W +: DATA_W]);
            avg_o[(2-i)*DATA_W +: DATA_W] = DATA_W'(sum[i] >> WIN_LOG2);
            acc_d[i] = acc_q[i];
            if (frame_start_i) begin
                acc_d[i] = pix_valid_i ? ACC_W'(pix_i[(2-i)*DATA_W +: DATA_W]) : '0;
            end else if (pix_valid_i) begin
                acc_d[i] = close_o ? '0 : sum[i];
            end
        end
        if (frame_start_i) begin
            cnt_d = pix_valid_i ? WIN_LOG2'(1) : '0;
        end else if (pix_valid_i) begin
            cnt_d = cnt_q + WIN_LOG2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < 3; i++) acc_q[i] <= '0;
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < 3; i++) acc_q[i] <= acc_d[i];
        end
    end

endmodule

// File: rtl/color_classifier.sv
// Windowed RGB average, dominant-colour classification with debounce, and LED indication.
module color_classifier
    import color_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WIN_LOG2   = DEF_WIN_LOG2,
    parameter int STABLE_N   = DEF_STABLE_N,
    parameter int BW_TOL     = DEF_BW_TOL,
    parameter int DOM_MARGIN = DEF_DOM_MARGIN,
    parameter int LED_MODE   = 0
) (
    input  logic              clk_100MHz,
    input  logic              Rst,
    color_classifier_if.slave bus,
    output logic [1:0]        state_dbg
);
    localparam int CW     = DATA_W + 1;
    localparam int STAB_W = $clog2(STABLE_N + 1);
    localparam logic [CW-1:0] BLACK_LIM = CW'(BW_TOL);
    localparam logic [CW-1:0] WHITE_LIM = CW'((2 ** DATA_W) - 1 - BW_TOL);
    localparam logic [CW-1:0] MARGIN    = CW'(DOM_MARGIN);

    logic                vsync_q;
    logic                frame_start;
    logic                win_close;
    logic [3*DATA_W-1:0] win_avg;

    state_t              state_q, state_d;
    logic [3*DATA_W-1:0] avg_q, avg_d;
    class_t              cand_q, cand_d;
    class_t              class_q, class_d;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic                valid_q, valid_d;
    logic                change_q, change_d;
    logic [2:0]          led_q, led_d;

    assign frame_start = bus.RGB_VSync & ~vsync_q;

    color_window_acc #(
        .DATA_W   (DATA_W),
        .WIN_LOG2 (WIN_LOG2)
    ) u_window_acc (
        .clk           (clk_100MHz),
        .rst           (Rst),
        .pix_valid_i   (bus.RGB_VDE),
        .frame_start_i (frame_start),
        .pix_i         (bus.RGB_Data),
        .close_o       (win_close),
        .avg_o         (win_avg)
    );

    // Widened by one bit so channel + margin never wraps.
    function automatic class_t classify(input logic [3*DATA_W-1:0] px);
        logic [CW-1:0] r, g, b;
        class_t        c;
        r = CW'(px[3*DATA_W-1 -: DATA_W]);
        g = CW'(px[2*DATA_W-1 -: DATA_W]);
        b = CW'(px[DATA_W-1:0]);
        if (r < BLACK_LIM && g < BLACK_LIM && b < BLACK_LIM)       c = CLS_BLACK;
        else if (r > WHITE_LIM && g > WHITE_LIM && b > WHITE_LIM)  c = CLS_WHITE;
        else if (r >= g + MARGIN && r >= b + MARGIN)               c = CLS_RED;
        else if (g >= r + MARGIN && g >= b + MARGIN)               c = CLS_GREEN;
        else if (b >= r + MARGIN && b >= g + MARGIN)               c = CLS_BLUE;
        else                                                       c = CLS_MIXED;
        return c;
    endfunction

    // Returns {R,G,B}.
    function automatic logic [2:0] led_map(input class_t c);
        logic [2:0] l;
        if (LED_MODE == 1) begin
            l = (c == CLS_BLACK || c == CLS_WHITE) ? 3'b100 : 3'b010;
        end else begin
            case (c)
                CLS_RED:   l = 3'b100;
                CLS_GREEN: l = 3'b010;
                CLS_BLUE:  l = 3'b001;
                CLS_WHITE: l = 3'b111;
                default:   l = 3'b000;
            endcase
        end
        return l;
    endfunction

    always_comb begin
        case (state_q)
            ST_AVG:      state_d = ST_CLASSIFY;
            ST_CLASSIFY: state_d = ST_COMMIT;
            default:     state_d = ST_ACCUM;
        endcase
        if (win_close) state_d = ST_AVG;

        avg_d  = win_close ? win_avg : avg_q;
        cand_d = cand_q;
        stab_d = stab_q;
        if (state_q == ST_AVG) begin
            cand_d = classify(avg_q);
            if (cand_d == cand_q) begin
                stab_d = (stab_q == STAB_W'(STABLE_N)) ? stab_q : stab_q + STAB_W'(1);
            end else begin
                stab_d = STAB_W'(1);
            end
        end

        valid_d  = (state_q == ST_CLASSIFY);
        class_d  = class_q;
        change_d = 1'b0;
        if (state_q == ST_CLASSIFY && stab_q == STAB_W'(STABLE_N)) begin
            class_d  = cand_q;
            change_d = (cand_q != class_q);
        end

        led_d = led_map(class_q);
    end

    always_ff @(posedge clk_100MHz) begin
        if (Rst) begin
            vsync_q  <= 1'b0;
            state_q  <= ST_ACCUM;
            avg_q    <= '0;
            cand_q   <= CLS_NONE;
            class_q  <= CLS_NONE;
            stab_q   <= '0;
            valid_q  <= 1'b0;
            change_q <= 1'b0;
            led_q    <= led_map(CLS_NONE);
        end else begin
            vsync_q  <= bus.RGB_VSync;
            state_q  <= state_d;
            avg_q    <= avg_d;
            cand_q   <= cand_d;
            class_q  <= class_d;
            stab_q   <= stab_d;
            valid_q  <= valid_d;
            change_q <= change_d;
            led_q    <= led_d;
        end
    end

    assign bus.Avg_RGB      = avg_q;
    assign bus.Class_Code   = class_q;
    assign bus.Class_Valid  = valid_q;
    assign bus.Class_Change = change_q;
    assign bus.LED_R        = led_q[2];
    assign bus.LED_G        = led_q[1];
    assign bus.LED_B        = led_q[0];
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_color_classifier.sv
// Self-checking bench: a window-level reference model feeds an expected queue checked on Class_Valid.
`timescale 1ns/1ps
module tb_color_classifier;
    import color_pkg::*;

    localparam int DW  = 8;
    localparam int WL  = 10;
    localparam int WIN = 1 << WL;

    // ---------------- clock / reset ----------------
    logic clk_100MHz = 1'b0;
    logic Rst        = 1'b1;
    always #5 clk_100MHz = ~clk_100MHz;

    color_classifier_if #(.DATA_W(DW)) bus0 ();
    color_classifier_if #(.DATA_W(DW)) bus1 ();
    logic [1:0] state0, state1;

    assign bus1.RGB_Data  = bus0.RGB_Data;
    assign bus1.RGB_VDE   = bus0.RGB_VDE;
    assign bus1.RGB_VSync = bus0.RGB_VSync;

    color_classifier #(.LED_MODE(0)) dut0 (
        .clk_100MHz (clk_100MHz),
        .Rst        (Rst),
        .bus        (bus0),
        .state_dbg  (state0)
    );

    color_classifier #(.LED_MODE(1)) dut1 (
        .clk_100MHz (clk_100MHz),
        .Rst        (Rst),
        .bus        (bus1),
        .state_dbg  (state1)
    );

    // ---------------- counters / scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_change = 0;
    logic [27:0] exp_q[$];   // {avg R,G,B, class, change}

    int m_acc[3];
    int m_cnt;
    int m_prev;
    int m_stab;
    int m_class;
    bit m_vs;

    function automatic int tb_classify(input int r, input int g, input int b);
        if (r < 16 && g < 16 && b < 16)           return 1;
        if (r > 239 && g > 239 && b > 239)        return 2;
        if (r >= g + 32 && r >= b + 32)           return 3;
        if (g >= r + 32 && g >= b + 32)           return 4;
        if (b >= r + 32 && b >= g + 32)           return 5;
        return 6;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) m_acc[i] = 0;
        m_cnt   = 0;
        m_prev  = 0;
        m_stab  = 0;
        m_class = 0;
        m_vs    = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_close();
        int a[3];
        int cand;
        bit chg;
        for (int i = 0; i < 3; i++) a[i] = m_acc[i] / WIN;
        cand = tb_classify(a[0], a[1], a[2]);
        if (cand == m_prev) begin
            if (m_stab < 3) m_stab++;
        end else begin
            m_stab = 1;
        end
        m_prev = cand;
        chg    = 1'b0;
        if (m_stab == 3) begin
            chg     = (cand != m_class);
            m_class = cand;
        end
        exp_q.push_back({8'(a[0]), 8'(a[1]), 8'(a[2]), 3'(m_class), chg});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [23:0] px, input bit vde, input bit vs);
        bit rise;
        @(posedge clk_100MHz);
        #1;
        bus0.RGB_Data  = px;
        bus0.RGB_VDE   = vde;
        bus0.RGB_VSync = vs;
        rise = vs && !m_vs;
        m_vs = vs;
        if (rise) begin
            for (int i = 0; i < 3; i++) m_acc[i] = vde ? int'(px[23-8*i -: 8]) : 0;
            m_cnt = vde ? 1 : 0;
        end else if (vde) begin
            for (int i = 0; i < 3; i++) m_acc[i] += int'(px[23-8*i -: 8]);
            m_cnt++;
            if (m_cnt == WIN) begin
                model_close();
                for (int i = 0; i < 3; i++) m_acc[i] = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic send_window(input logic [23:0] px);
        for (int i = 0; i < WIN; i++) drive(px, 1'b1, 1'b0);
        drive(24'h0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        @(posedge clk_100MHz);
        #1;
        Rst            = 1'b1;
        bus0.RGB_VDE   = 1'b0;
        bus0.RGB_VSync = 1'b0;
        bus0.RGB_Data  = '0;
        model_clear();
        repeat (3) @(posedge clk_100MHz);
        #1;
        Rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(posedge clk_100MHz);
            k++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d windows still pending, required 0", name, exp_q.size());
        end
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
    endtask

    // ---------------- monitor ----------------
    logic [27:0] mon_e, mon_got;
    always @(negedge clk_100MHz) begin
        if (!Rst && bus0.Class_Valid) begin
            n_valid++;
            if (bus0.Class_Change) n_change++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: Class_Valid=1 at %0t with no window pending", $time);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_got = {bus0.Avg_RGB, bus0.Class_Code, bus0.Class_Change};
                if (mon_got !== mon_e) begin
                    n_fail++;
                    $display("FAIL window_result: got avg=%h class=%0d chg=%0b, required avg=%h class=%0d chg=%0b",
                             mon_got[27:4], mon_got[3:1], mon_got[0], mon_e[27:4], mon_e[3:1], mon_e[0]);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        Rst            = 1'b1;
        bus0.RGB_VDE   = 1'b0;
        bus0.RGB_VSync = 1'b0;
        bus0.RGB_Data  = '0;
        model_clear();
        repeat (3) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        n_checks++;
        if ({bus0.Avg_RGB, bus0.Class_Code, bus0.Class_Valid, bus0.Class_Change} !== 29'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: avg=%h class=%0d valid=%0b chg=%0b, required all 0",
                     bus0.Avg_RGB, bus0.Class_Code, bus0.Class_Valid, bus0.Class_Change);
        end
        n_checks++;
        if ({bus0.LED_R, bus0.LED_G, bus0.LED_B} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_led_mode0: RGB=%b, required 000", {bus0.LED_R, bus0.LED_G, bus0.LED_B});
        end
        n_checks++;
        if ({bus1.LED_R, bus1.LED_G, bus1.LED_B} !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_led_mode1: RGB=%b, required 010", {bus1.LED_R, bus1.LED_G, bus1.LED_B});
        end
        n_checks++;
        if (state0 !== 2'(ST_ACCUM)) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d, required %0d", state0, ST_ACCUM);
        end
        @(posedge clk_100MHz);
        #1;
        Rst = 1'b0;
    endtask

    task automatic test_red();
        int v0, c0;
        v0 = n_valid;
        c0 = n_change;
        for (int w = 0; w < 3; w++) send_window(24'hFF1010);
        wait_drain("red");
        n_checks++;
        if (n_valid - v0 !== 3) begin
            n_fail++;
            $display("FAIL red_valid_count: %0d pulses, required 3", n_valid - v0);
        end
        n_checks++;
        if (n_change - c0 !== 1) begin
            n_fail++;
            $display("FAIL red_change_count: %0d pulses, required 1", n_change - c0);
        end
        n_checks++;
        if (bus0.Class_Code !== 3'd3) begin
            n_fail++;
            $display("FAIL red_class: %0d, required 3", bus0.Class_Code);
        end
        n_checks++;
        if ({bus0.LED_R, bus0.LED_G, bus0.LED_B} !== 3'b100) begin
            n_fail++;
            $display("FAIL red_leds: RGB=%b, required 100", {bus0.LED_R, bus0.LED_G, bus0.LED_B});
        end
        n_checks++;
        if ({bus1.LED_R, bus1.LED_G, bus1.LED_B} !== 3'b010) begin
            n_fail++;
            $display("FAIL red_leds_mode1: RGB=%b, required 010", {bus1.LED_R, bus1.LED_G, bus1.LED_B});
        end
    endtask

    task automatic test_alternate();
        int v0;
        apply_reset();
        v0 = n_valid;
        for (int w = 0; w < 4; w++) send_window(w[0] ? 24'hFFFFFF : 24'h000000);
        wait_drain("alternate");
        n_checks++;
        if (n_valid - v0 !== 4) begin
            n_fail++;
            $display("FAIL alt_valid_count: %0d pulses, required 4", n_valid - v0);
        end
        n_checks++;
        if (bus0.Class_Code !== 3'd0) begin
            n_fail++;
            $display("FAIL alt_class: %0d, required 0", bus0.Class_Code);
        end
    endtask

    task automatic test_avg_mixed();
        for (int i = 0; i < WIN / 2; i++) drive(24'h000000, 1'b1, 1'b0);
        for (int i = 0; i < WIN / 2; i++) drive(24'hFEFEFE, 1'b1, 1'b0);
        drive(24'h0, 1'b0, 1'b0);
        wait_drain("mixed");
        n_checks++;
        if (bus0.Avg_RGB !== 24'h7F7F7F) begin
            n_fail++;
            $display("FAIL mixed_avg: %h, required 7f7f7f", bus0.Avg_RGB);
        end
        n_checks++;
        if (dut0.cand_q !== CLS_MIXED) begin
            n_fail++;
            $display("FAIL mixed_candidate: %0d, required %0d", dut0.cand_q, CLS_MIXED);
        end
    endtask

    task automatic test_vsync();
        int v0;
        v0 = n_valid;
        for (int i = 0; i < 700; i++) drive(24'h808080, 1'b1, 1'b0);
        drive(24'h0, 1'b0, 1'b1);
        send_window(24'h10FF10);
        wait_drain("vsync_idle");
        n_checks++;
        if (n_valid - v0 !== 1) begin
            n_fail++;
            $display("FAIL vsync_valid_count: %0d pulses, required 1", n_valid - v0);
        end
        n_checks++;
        if (bus0.Avg_RGB !== 24'h10FF10) begin
            n_fail++;
            $display("FAIL vsync_avg: %h, required 10ff10", bus0.Avg_RGB);
        end
        // Frame edge arriving together with a pixel: that pixel opens the new window.
        for (int i = 0; i < 300; i++) drive(24'hFFFFFF, 1'b1, 1'b0);
        for (int i = 0; i < WIN; i++) drive(24'h10FF10, 1'b1, 1'b1);
        drive(24'h0, 1'b0, 1'b0);
        wait_drain("vsync_pixel");
        n_checks++;
        if (n_valid - v0 !== 2) begin
            n_fail++;
            $display("FAIL vsync_pixel_valid_count: %0d pulses, required 2", n_valid - v0);
        end
        n_checks++;
        if (bus0.Avg_RGB !== 24'h10FF10) begin
            n_fail++;
            $display("FAIL vsync_pixel_avg: %h, required 10ff10", bus0.Avg_RGB);
        end
    endtask

    task automatic test_reset_mid();
        int v0;
        for (int i = 0; i < WIN; i++) drive(24'h2040C0, 1'b1, 1'b0);
        drive(24'h0, 1'b0, 1'b0);
        @(posedge clk_100MHz);
        #1;
        Rst = 1'b1;
        model_clear();
        v0 = n_valid;
        @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        n_checks++;
        if ({bus0.Avg_RGB, bus0.Class_Code, bus0.Class_Valid, bus0.Class_Change} !== 29'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: avg=%h class=%0d valid=%0b chg=%0b, required all 0",
                     bus0.Avg_RGB, bus0.Class_Code, bus0.Class_Valid, bus0.Class_Change);
        end
        n_checks++;
        if ({bus0.LED_R, bus0.LED_G, bus0.LED_B, bus1.LED_R, bus1.LED_G, bus1.LED_B} !== 6'b000010) begin
            n_fail++;
            $display("FAIL midreset_leds: mode0=%b mode1=%b, required 000 / 010",
                     {bus0.LED_R, bus0.LED_G, bus0.LED_B}, {bus1.LED_R, bus1.LED_G, bus1.LED_B});
        end
        n_checks++;
        if (bus0.Class_Valid !== 1'b0 || state0 !== 2'(ST_ACCUM)) begin
            n_fail++;
            $display("FAIL midreset_state: valid=%0b state=%0d, required 0 / %0d", bus0.Class_Valid, state0, ST_ACCUM);
        end
        @(posedge clk_100MHz);
        #1;
        Rst = 1'b0;
        repeat (10) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        n_checks++;
        if (n_valid !== v0) begin
            n_fail++;
            $display("FAIL midreset_no_valid: %0d pulses after reset, required 0", n_valid - v0);
        end
    endtask

    task automatic test_led_mode1();
        apply_reset();
        for (int w = 0; w < 3; w++) send_window(24'h050505);
        wait_drain("black");
        n_checks++;
        if (bus1.Class_Code !== 3'd1) begin
            n_fail++;
            $display("FAIL black_class_mode1: %0d, required 1", bus1.Class_Code);
        end
        n_checks++;
        if ({bus1.LED_R, bus1.LED_G, bus1.LED_B} !== 3'b100) begin
            n_fail++;
            $display("FAIL black_leds_mode1: RGB=%b, required 100", {bus1.LED_R, bus1.LED_G, bus1.LED_B});
        end
        n_checks++;
        if ({bus0.LED_R, bus0.LED_G, bus0.LED_B} !== 3'b000) begin
            n_fail++;
            $display("FAIL black_leds_mode0: RGB=%b, required 000", {bus0.LED_R, bus0.LED_G, bus0.LED_B});
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_red();
        test_alternate();
        test_avg_mixed();
        test_vsync();
        test_reset_mid();
        test_led_mode1();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d windows never reported, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
